// File: rtl/core_wb_pkg.sv
// Shared write-back constants: register-file geometry and helpers.
package core_wb_pkg;

    localparam int XLEN       = 32;
    localparam int RADDR_W    = 5;
    localparam int NUM_REGS   = 32;
    localparam int FIFO_DEPTH = 2;

    // x0 is hardwired to zero; writes to it are architecturally dropped.
    localparam logic [RADDR_W-1:0] REG_ZERO = '0;
    localparam logic               WE_ON    = 1'b1;

    // True when the address names a real (writable) register.
    function automatic logic is_wr_reg(input logic [RADDR_W-1:0] a);
        return a != REG_ZERO;
    endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// Small synchronous FIFO, power-of-two depth, head is visible before pop.
module core_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Requests against a full/empty buffer are ignored rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and occupancy; simultaneous push+pop keeps count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/core_wb.sv
// Write-back arbiter: merges ALU and load results onto the single RF write
// port and keeps the scoreboard of outstanding long-latency destinations.
module core_wb
    import core_wb_pkg::*;
#(
    parameter int XLEN       = core_wb_pkg::XLEN,
    parameter int RADDR_W    = core_wb_pkg::RADDR_W,
    parameter int NUM_REGS   = core_wb_pkg::NUM_REGS,
    parameter int FIFO_DEPTH = core_wb_pkg::FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_we_in,
    input  logic [RADDR_W-1:0]  ex_addr_in,
    input  logic [XLEN-1:0]     ex_data_in,
    input  logic                issue_valid_in,
    input  logic [RADDR_W-1:0]  issue_rd_in,
    input  logic [RADDR_W-1:0]  chk_rs1_in,
    input  logic [RADDR_W-1:0]  chk_rs2_in,
    input  logic [RADDR_W-1:0]  chk_rd_in,
    input  logic                lsu_valid_in,
    input  logic [RADDR_W-1:0]  lsu_addr_in,
    input  logic [XLEN-1:0]     lsu_data_in,
    output logic                lsu_ready_out,
    output logic                we_out,
    output logic [RADDR_W-1:0]  write_addr_out,
    output logic [XLEN-1:0]     write_data_out,
    output logic                hazard_out,
    output logic [NUM_REGS-1:0] pending_out
);

    localparam int ENT_W = RADDR_W + XLEN;

    logic               fifo_full, fifo_empty;
    logic               push, pop, ex_sel;
    logic [ENT_W-1:0]   head;
    logic [RADDR_W-1:0] head_addr;
    logic [XLEN-1:0]    head_data;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] set_m, clr_m;

    assign head_addr = head[XLEN +: RADDR_W];
    assign head_data = head[XLEN-1:0];

    // EX owns the port only for a real destination; an x0 write yields the slot.
    assign ex_sel        = ex_we_in && is_wr_reg(ex_addr_in);
    assign lsu_ready_out = !rst && !fifo_full;
    assign push          = lsu_valid_in && lsu_ready_out;
    assign pop           = !rst && !ex_sel && !fifo_empty;

    core_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({lsu_addr_in, lsu_data_in}),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Commit mux: EX first, else the buffered load head; x0 loads pop silently.
    always_comb begin
        we_out         = 1'b0;
        write_addr_out = '0;
        write_data_out = '0;
        if (!rst) begin
            if (ex_sel) begin
                we_out         = WE_ON;
                write_addr_out = ex_addr_in;
                write_data_out = ex_data_in;
            end else if (!fifo_empty && is_wr_reg(head_addr)) begin
                we_out         = WE_ON;
                write_addr_out = head_addr;
                write_data_out = head_data;
            end
        end
    end

    // Scoreboard next-state: issue sets, load retirement clears, set wins.
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (issue_valid_in && is_wr_reg(issue_rd_in)) set_m[issue_rd_in] = 1'b1;
        if (pop) clr_m[head_addr] = 1'b1;
        pend_d    = (pend_q & ~clr_m) | set_m;
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    // RAW/WAW check against registered scoreboard; x0 never stalls.
    always_comb begin
        hazard_out = 1'b0;
        if (!rst) begin
            if (is_wr_reg(chk_rs1_in) && pend_q[chk_rs1_in]) hazard_out = 1'b1;
            if (is_wr_reg(chk_rs2_in) && pend_q[chk_rs2_in]) hazard_out = 1'b1;
            if (is_wr_reg(chk_rd_in)  && pend_q[chk_rd_in])  hazard_out = 1'b1;
        end
    end

    assign pending_out = rst ? '0 : pend_q;

endmodule

// File: tb/tb_core_wb.sv
// Directed bench for core_wb: expected RF writes are queued as stimulus is
// driven and matched in order against every cycle the DUT asserts we_out.
module tb_core_wb;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int NR   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_we_in;
    logic [RW-1:0]   ex_addr_in;
    logic [XLEN-1:0] ex_data_in;
    logic            issue_valid_in;
    logic [RW-1:0]   issue_rd_in;
    logic [RW-1:0]   chk_rs1_in, chk_rs2_in, chk_rd_in;
    logic            lsu_valid_in;
    logic [RW-1:0]   lsu_addr_in;
    logic [XLEN-1:0] lsu_data_in;
    logic            lsu_ready_out;
    logic            we_out;
    logic [RW-1:0]   write_addr_out;
    logic [XLEN-1:0] write_data_out;
    logic            hazard_out;
    logic [NR-1:0]   pending_out;

    int n_cmp = 0;
    int n_mis = 0;
    logic [RW+XLEN-1:0] exp_q [$];
    logic [RW+XLEN-1:0] ld_stage [$];

    always #5 clk = ~clk;

    core_wb dut (
        .clk            (clk),
        .rst            (rst),
        .ex_we_in       (ex_we_in),
        .ex_addr_in     (ex_addr_in),
        .ex_data_in     (ex_data_in),
        .issue_valid_in (issue_valid_in),
        .issue_rd_in    (issue_rd_in),
        .chk_rs1_in     (chk_rs1_in),
        .chk_rs2_in     (chk_rs2_in),
        .chk_rd_in      (chk_rd_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_addr_in    (lsu_addr_in),
        .lsu_data_in    (lsu_data_in),
        .lsu_ready_out  (lsu_ready_out),
        .we_out         (we_out),
        .write_addr_out (write_addr_out),
        .write_data_out (write_data_out),
        .hazard_out     (hazard_out),
        .pending_out    (pending_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Any asserted write must match the oldest expected write.
    task automatic check_wr();
        logic [RW+XLEN-1:0] e;
        if (we_out !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $error("FAIL wr_unexpected: observed=%0d/%h expected=no write",
                       write_addr_out, write_data_out);
            end else begin
                e = exp_q.pop_front();
                assert ({we_out, write_addr_out, write_data_out} === {1'b1, e}) else begin
                    n_mis++;
                    $error("FAIL wr_data: observed=%b/%0d/%h expected=1/%0d/%h",
                           we_out, write_addr_out, write_data_out, e[XLEN +: RW], e[XLEN-1:0]);
                end
            end
        end
    endtask

    // Inputs are driven 1ns after the edge; outputs sampled 2ns later.
    task automatic cyc();
        #2;
        check_wr();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_we_in = 0; ex_addr_in = 0; ex_data_in = 0;
        issue_valid_in = 0; issue_rd_in = 0;
        lsu_valid_in = 0; lsu_addr_in = 0; lsu_data_in = 0;
    endtask

    initial begin
        idle();
        chk_rs1_in = 0; chk_rs2_in = 0; chk_rd_in = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        // Reset with busy inputs: everything must stay quiet.
        ex_we_in = 1; ex_addr_in = 5; ex_data_in = 32'h1111_1111;
        lsu_valid_in = 1; lsu_addr_in = 8; lsu_data_in = 32'h2222_2222;
        issue_valid_in = 1; issue_rd_in = 3; chk_rs1_in = 3;
        #2;
        chk("rst_we", we_out, 0);
        chk("rst_addr", write_addr_out, 0);
        chk("rst_data", write_data_out, 0);
        chk("rst_ready", lsu_ready_out, 0);
        chk("rst_pending", pending_out, 0);
        chk("rst_hazard", hazard_out, 0);
        @(posedge clk); #1;
        idle(); chk_rs1_in = 0; rst = 1'b0;
        #2;
        chk("post_rst_ready", lsu_ready_out, 1);
        chk("post_rst_pending", pending_out, 0);
        chk("post_rst_we", we_out, 0);
        @(posedge clk); #1;

        // EX only: same-cycle commit.
        ex_we_in = 1; ex_addr_in = 5; ex_data_in = 32'hDEAD_BEEF;
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        cyc();
        idle();

        // Long-latency load: scoreboard set, hazard, commit, clear.
        issue_valid_in = 1; issue_rd_in = 7;
        cyc();
        idle(); chk_rs1_in = 7;
        #2;
        chk("ld_hazard_rs1", hazard_out, 1);
        chk("ld_pending7", pending_out, 32'h0000_0080);
        chk_rs1_in = 0; chk_rs2_in = 7;
        #1;
        chk("ld_hazard_rs2", hazard_out, 1);
        chk_rs2_in = 0; chk_rs1_in = 7;
        lsu_valid_in = 1; lsu_addr_in = 7; lsu_data_in = 32'h1234_5678;
        exp_q.push_back({5'd7, 32'h1234_5678});
        #1;
        chk("ld_ready", lsu_ready_out, 1);
        chk("ld_no_same_cycle", we_out, 0);
        cyc();
        idle();
        #1;
        chk("ld_commit_we", we_out, 1);
        chk("ld_hazard_during_commit", hazard_out, 1);
        cyc();
        #2;
        chk("ld_hazard_cleared", hazard_out, 0);
        chk("ld_pending_cleared", pending_out, 0);
        chk("ld_q_drained", exp_q.size(), 0);
        chk_rs1_in = 0;

        // Collision: EX keeps the port, loads buffer then drain in order.
        for (int i = 0; i < 3; i++) begin
            ex_we_in = 1; ex_addr_in = 4; ex_data_in = 32'h4000_0000 + i;
            exp_q.push_back({5'd4, 32'h4000_0000 + i});
            lsu_valid_in = 1; lsu_addr_in = 3; lsu_data_in = 32'h3000_0000 + i;
            #1;
            chk($sformatf("col_ready_%0d", i), lsu_ready_out, (i < 2) ? 1 : 0);
            if (i < 2) ld_stage.push_back({5'd3, 32'h3000_0000 + i});
            cyc();
        end
        idle();
        while (ld_stage.size() != 0) exp_q.push_back(ld_stage.pop_front());
        #1;
        chk("col_full_ready", lsu_ready_out, 0);
        cyc();
        cyc();
        #2;
        chk("col_drain_ready", lsu_ready_out, 1);
        chk("col_drain_we", we_out, 0);
        chk("col_q_drained", exp_q.size(), 0);

        // x0: EX write to x0 yields the port to the buffered head.
        lsu_valid_in = 1; lsu_addr_in = 9; lsu_data_in = 32'h0000_9999;
        exp_q.push_back({5'd9, 32'h0000_9999});
        cyc();
        idle();
        ex_we_in = 1; ex_addr_in = 0; ex_data_in = 32'h0000_0BAD;
        cyc();
        idle();
        // Load to x0 pops without a write.
        lsu_valid_in = 1; lsu_addr_in = 0; lsu_data_in = 32'h0000_0001;
        cyc();
        idle();
        #2;
        chk("x0_load_no_we", we_out, 0);
        cyc();
        issue_valid_in = 1; issue_rd_in = 0;
        cyc();
        idle();
        #2;
        chk("x0_issue_pending", pending_out, 0);
        chk("x0_q_drained", exp_q.size(), 0);

        // Set and clear of the same bit in one cycle: set wins.
        issue_valid_in = 1; issue_rd_in = 6;
        cyc();
        idle();
        lsu_valid_in = 1; lsu_addr_in = 6; lsu_data_in = 32'h0000_0066;
        exp_q.push_back({5'd6, 32'h0000_0066});
        cyc();
        idle();
        issue_valid_in = 1; issue_rd_in = 6;
        cyc();
        idle(); chk_rd_in = 6;
        #2;
        chk("setclr_pending6", pending_out, 32'h0000_0040);
        chk("setclr_waw_hazard", hazard_out, 1);
        lsu_valid_in = 1; lsu_addr_in = 6; lsu_data_in = 32'h0000_0067;
        exp_q.push_back({5'd6, 32'h0000_0067});
        cyc();
        idle();
        cyc();
        #2;
        chk("setclr_final_pending", pending_out, 0);
        chk("setclr_final_hazard", hazard_out, 0);
        chk_rd_in = 0;

        // Reset mid-flight with two loads buffered behind EX traffic.
        issue_valid_in = 1; issue_rd_in = 10;
        ex_we_in = 1; ex_addr_in = 11; ex_data_in = 32'h0000_00B0;
        exp_q.push_back({5'd11, 32'h0000_00B0});
        lsu_valid_in = 1; lsu_addr_in = 10; lsu_data_in = 32'h0000_000A;
        cyc();
        issue_valid_in = 0;
        ex_data_in = 32'h0000_00B1;
        exp_q.push_back({5'd11, 32'h0000_00B1});
        lsu_addr_in = 12; lsu_data_in = 32'h0000_000C;
        cyc();
        idle(); chk_rs1_in = 10;
        ex_we_in = 1; ex_addr_in = 11; ex_data_in = 32'h0000_00B2;
        exp_q.push_back({5'd11, 32'h0000_00B2});
        #1;
        chk("mid_pending10", pending_out, 32'h0000_0400);
        chk("mid_full_ready", lsu_ready_out, 0);
        cyc();
        idle();
        rst = 1'b1;
        #2;
        chk("mid_rst_we", we_out, 0);
        chk("mid_rst_pending", pending_out, 0);
        chk("mid_rst_hazard", hazard_out, 0);
        chk("mid_rst_ready", lsu_ready_out, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", lsu_ready_out, 1);
        chk("mid_rel_pending", pending_out, 0);
        chk("mid_rel_hazard", hazard_out, 0);
        chk("mid_rel_we", we_out, 0);
        cyc();
        cyc();
        chk("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/core_wb.md
Name: core_wb

Overview:
- Write-back arbiter and scoreboard that drives the single register-file write port (we, write address, write data).
- Merges two result sources onto that port:
  - single-cycle ALU results from core_ex;
  - long-latency load results returned by the load/store unit, which may arrive while ALU results are also retiring.
- Tracks outstanding long-latency destinations in a 32-bit scoreboard and raises a hazard to core_id when an instruction reads or overwrites a pending register.

Parameters:
- XLEN, 32, data width of register values.
- RADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; scoreboard width.
- FIFO_DEPTH, 2, load-result buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_we_in  in  1  ALU result valid this cycle
- ex_addr_in  in  RADDR_W  ALU destination register
- ex_data_in  in  XLEN  ALU result
- issue_valid_in  in  1  core_id issues a long-latency op this cycle
- issue_rd_in  in  RADDR_W  destination of issued long-latency op
- chk_rs1_in  in  RADDR_W  rs1 of instruction in ID
- chk_rs2_in  in  RADDR_W  rs2 of instruction in ID
- chk_rd_in  in  RADDR_W  rd of instruction in ID (0 if none)
- lsu_valid_in  in  1  load result valid
- lsu_addr_in  in  RADDR_W  load destination register
- lsu_data_in  in  XLEN  load data
- lsu_ready_out  out  1  buffer can accept a load result
- we_out  out  1  register-file write enable
- write_addr_out  out  RADDR_W  register-file write address
- write_data_out  out  XLEN  register-file write data
- hazard_out  out  1  core_id must stall
- pending_out  out  NUM_REGS  scoreboard vector

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk.
  - Reset clears the FIFO and the scoreboard.
  - While rst is high: we_out=0, write_addr_out=0, write_data_out=0, hazard_out=0, pending_out=0, lsu_ready_out=0.
- Load buffer: FIFO_DEPTH-entry FIFO of {addr,data}.
  - Push when lsu_valid_in & lsu_ready_out.
  - lsu_ready_out = !full, computed from registered count.
  - Push to a full FIFO cannot occur.
- Commit arbitration (combinational, zero added latency):
  - ex_we_in=1 and ex_addr_in!=0: drive the EX result. EX has fixed priority and the FIFO head waits.
  - Otherwise, FIFO non-empty: drive the head and pop it at the clock edge.
  - Otherwise: we_out=0; address/data outputs=0.
- x0 handling: an EX write with addr 0 is dropped and frees the slot for the FIFO head. A load result to x0 is popped with we_out=0.
- Simultaneous push and pop: the count is unchanged. With an empty FIFO and no EX write, a pushed load commits the next cycle (1-cycle latency through the buffer).
- Scoreboard:
  - Set: on issue_valid_in with issue_rd_in!=0, bit[issue_rd_in] is set at the clock edge.
  - Clear: on a FIFO pop whose addr matches a pending bit, that bit is cleared at the clock edge.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Bit 0 is always 0.
- hazard_out = pending[chk_rs1_in] | pending[chk_rs2_in] | pending[chk_rd_in], with index 0 ignored. This covers RAW and WAW; it is combinational from the registered scoreboard.
- An EX write to a pending register cannot occur legally (blocked by the WAW hazard). If it does occur, it is written anyway and the scoreboard is untouched.
- Reset mid-operation: buffered load results are discarded, with no commit in the reset cycle.

Decomposition:
- XLEN, RADDR_W, NUM_REGS, the zero-register constant, and the write-enable constant belong in the shared defines file.
- Sub-module core_wb_fifo: synchronous FIFO with push/pop/full/empty/head outputs and DEPTH/WIDTH parameters, reusable by the LSU.
- Arbitration and scoreboard stay in core_wb.

Test Plan:
- EX only: ex_we=1, addr=5, data=0xDEADBEEF -> same-cycle we_out=1, write_addr_out=5, write_data_out=0xDEADBEEF.
- Load commit: issue rd=7, then chk_rs1=7 -> hazard_out=1. Load returns addr=7, data=0x12345678 with no EX write -> commit the next cycle, pending[7] cleared, hazard_out=0 the cycle after.
- Collision: lsu_valid with addr=3 while ex_we with addr=4 on 3 consecutive cycles -> EX commits each cycle. The FIFO fills at 2, lsu_ready_out drops to 0, and loads drain in order once EX idles.
- x0: ex_we with addr=0 while FIFO head addr=9 -> we_out writes reg 9. Issue rd=0 -> pending_out stays 0.
- Set/clear same cycle: pop a load to rd=6 while issue_rd=6 -> pending[6]=1 afterwards.
- Reset mid-flight: 2 loads buffered, assert rst for 1 cycle -> no writes, pending_out=0, FIFO empty, lsu_ready_out=1 after release.
